// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU op encodings, R-type funct codes
// and the buffered entry layout.
package alu_issue_pkg;

  localparam int ISSUE_DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [ISSUE_DATA_W-1:0] a;
    logic [ISSUE_DATA_W-1:0] b;
    logic [2:0]              op;
  } issue_entry_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: maps funct to the 3-bit ALU op and flags
// unsupported codes as illegal.
module alu_funct_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       legal
);

  always_comb begin
    op    = OP_AND;
    legal = 1'b1;
    case (funct)
      FN_AND:  op = OP_AND;
      FN_OR:   op = OP_OR;
      FN_ADD:  op = OP_ADD;
      FN_SUB:  op = OP_SUB;
      FN_SLT:  op = OP_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes R-type requests into a small FIFO feeding the ALU and
// counts dropped illegal requests. Define ALU_ISSUE_IMM_EN for the immediate operand path.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
`ifdef ALU_ISSUE_IMM_EN
  input  logic              in_use_imm,
  input  logic [15:0]       in_imm,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [2:0]        dec_op;
  logic              dec_legal;
  logic              accept, push, pop, drop;
  logic [DATA_W-1:0] b_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  alu_funct_decode u_decode (
    .funct (in_funct),
    .op    (dec_op),
    .legal (dec_legal)
  );

`ifdef ALU_ISSUE_IMM_EN
  logic signed [DATA_W-1:0] imm_ext;
  assign imm_ext = {{(DATA_W-16){in_imm[15]}}, in_imm};
  assign b_in    = in_use_imm ? imm_ext : in_rt_val;
`else
  assign b_in = in_rt_val;
`endif

  // Handshake decode: in_ready depends on registered count only, so a pop never frees a slot same-cycle
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & dec_legal;
  assign drop      = accept & ~dec_legal;
  assign pop       = out_valid & out_ready;

  // Control state: pointers, occupancy and illegal tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      illegal_seen <= 1'b0;
      illegal_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) begin
        illegal_seen <= 1'b1;
        illegal_cnt  <= sat_inc(illegal_cnt);
      end
    end
  end

  // Entry storage: unreset, occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_rs_val, b: b_in, op: dec_op};
  end

  assign head   = mem[rd_ptr];
  assign alu_a  = out_valid ? head.a  : '0;
  assign alu_b  = out_valid ? head.b  : '0;
  assign alu_op = out_valid ? head.op : '0;

endmodule
